// File: rtl/ripple_carry_pkg.sv
// Shared constants for the ripple-carry adder slice.
// Only the default operand width lives here; each instance may override N.
package ripple_carry_pkg;

    localparam int unsigned RC_DEFAULT_N = 8;

endpackage

// File: rtl/ripple_carry_full_adder.sv
// One-bit full adder cell; the top chains N of these LSB to MSB.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry.sv
// N-bit ripple-carry adder with a single output register stage.
// The carry chain is combinational; sum, carry and out_valid are flopped once.
module ripple_carry
    import ripple_carry_pkg::*;
#(
    parameter int unsigned N = RC_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         carry,
    output logic         out_valid
);

    logic [N:0]   c;
    logic [N-1:0] s;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .s   (s[i]),
            .cout(c[i+1])
        );
    end

    logic [N-1:0] sum_d, sum_q;
    logic         carry_d, carry_q;
    logic         out_valid_d, out_valid_q;

    // Result registers hold across idle cycles; only the valid flag drops.
    always_comb begin
        sum_d       = sum_q;
        carry_d     = carry_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            sum_d       = s;
            carry_d     = c[N];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign carry     = carry_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ripple_carry.sv
// Randomised and directed bench for ripple_carry (N=8) against an
// arithmetic reference model of {carry,sum} = a + b + cin.
module tb_ripple_carry;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [N-1:0] a, b;
    logic         cin;
    logic [N-1:0] sum;
    logic         carry;
    logic         out_valid;

    int n_vec = 0;
    int n_err = 0;

    // reference state
    logic [N:0] m_res = '0;
    logic       m_vld = 1'b0;

    ripple_carry #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sum      (sum),
        .carry    (carry),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Drive one cycle, advance the model by the same edge, compare just after it.
    task automatic apply(input logic [N-1:0] ta, input logic [N-1:0] tb_,
                         input logic tc, input logic tv, input logic tr);
        a = ta; b = tb_; cin = tc; in_valid = tv; rst_n = tr;
        @(posedge clk);
        if (!tr) begin
            m_res = '0;
            m_vld = 1'b0;
        end else if (tv) begin
            m_res = (N+1)'(ta) + (N+1)'(tb_) + (N+1)'(tc);
            m_vld = 1'b1;
        end else begin
            m_vld = 1'b0;
        end
        #1;
        chk("model_res", 16'({carry, sum}), 16'(m_res));
        chk("model_vld", 16'(out_valid), 16'(m_vld));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;

        apply(8'h5A, 8'hA5, 1'b1, 1'b1, 1'b0);
        apply(8'h5A, 8'hA5, 1'b1, 1'b1, 1'b0);
        chk("reset_sum", 16'(sum), 16'h0000);
        chk("reset_carry", 16'(carry), 16'h0000);
        chk("reset_vld", 16'(out_valid), 16'h0000);

        apply(8'h18, 8'h18, 1'b1, 1'b1, 1'b1);
        chk("add_18_18", 16'({out_valid, carry, sum}), 16'h0231);

        apply(8'hAF, 8'hEE, 1'b0, 1'b1, 1'b1);
        chk("add_af_ee", 16'({out_valid, carry, sum}), 16'h039D);
        apply(8'h22, 8'h55, 1'b1, 1'b1, 1'b1);
        chk("add_22_55", 16'({out_valid, carry, sum}), 16'h0278);
        apply(8'h38, 8'hBB, 1'b1, 1'b1, 1'b1);
        chk("add_38_bb", 16'({out_valid, carry, sum}), 16'h02F4);

        apply(8'hFF, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("wrap", 16'({out_valid, carry, sum}), 16'h0300);
        apply(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
        chk("max", 16'({out_valid, carry, sum}), 16'h03FF);

        apply(8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
        chk("hold", 16'({out_valid, carry, sum}), 16'h01FF);

        // mid-stream reset discards the in-flight result
        apply(8'h10, 8'h20, 1'b0, 1'b1, 1'b1);
        apply(8'h77, 8'h77, 1'b1, 1'b1, 1'b0);
        chk("midrst", 16'({out_valid, carry, sum}), 16'h0000);
        apply(8'h77, 8'h77, 1'b1, 1'b0, 1'b1);
        chk("post_rst_idle", 16'({out_valid, carry, sum}), 16'h0000);
        apply(8'h77, 8'h77, 1'b1, 1'b1, 1'b1);
        chk("post_rst_first", 16'({out_valid, carry, sum}), 16'h02EF);

        for (int i = 0; i < 1000; i++) begin
            apply(N'($urandom), N'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) != 0), !(i == 500 || i == 501));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
